muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO architectural registers.
// One result bit per cycle: shift-add multiply, restoring divide, fixed latency.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic                  flush,
    input  logic                  we_hi,
    input  logic                  we_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q, b_q, opnd;
    logic [2*W-1:0]  acc;
    logic            neg_q, neg_r;

    logic            signed_op, is_div, last_iter, div0;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum, div_trial, div_diff;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [2*W-1:0]  mul_next, div_next, prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (en) begin
            case (state)
                IDLE: if (start && !flush) state_n = PREP;
                PREP: state_n = flush ? IDLE : CALC;
                CALC: begin
                    if (flush)          state_n = IDLE;
                    else if (last_iter) state_n = FIX;
                end
                FIX:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        signed_op = ~op_q[0];
        is_div    = op_q[1];
        last_iter = (cnt == CW'(W - 1));
        div0      = is_div && (b_q == '0);
        mag_a     = (signed_op && a_q[W-1]) ? -a_q : a_q;
        mag_b     = (signed_op && b_q[W-1]) ? -b_q : b_q;

        // acc holds {partial product, remaining multiplier} and shifts right
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd & {W{acc[0]}}};
        mul_next  = {mul_sum, acc[W-1:1]};

        // acc holds {remainder, dividend/quotient} and shifts left
        div_trial = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_trial - {1'b0, opnd};
        div_ge    = ~div_diff[W];
        div_rem   = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
        div_next  = {div_rem, acc[W-2:0], div_ge};

        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rem_fix   = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opnd        <= '0;
            acc         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (we_hi) hi <= wdata;
                    if (we_lo) lo <= wdata;
                    if (start && !flush) begin
                        op_q <= op;
                        a_q  <= srcA;
                        b_q  <= srcB;
                    end
                end
                PREP: begin
                    acc   <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                    opnd  <= is_div ? mag_b : mag_a;
                    neg_q <= signed_op & (a_q[W-1] ^ b_q[W-1]);
                    neg_r <= signed_op & a_q[W-1];
                    cnt   <= '0;
                end
                CALC: begin
                    if (flush || last_iter) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (!flush) acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= div0;
                        if (!is_div) begin
                            hi <= prod_fix[2*W-1:W];
                            lo <= prod_fix[W-1:0];
                        end else if (div0) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [W-1:0]  srcA = '0, srcB = '0, wdata = '0;
    logic          flush = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .flush(flush), .we_hi(we_hi), .we_lo(we_lo),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain SV arithmetic on 64-bit integers.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                pu = 64'(a) * 64'(b);
                eh = pu[63:32];
                el = pu[31:0];
            end
            default: begin
                if (b == 0) begin
                    el = '1;
                    eh = a;
                    ez = 1'b1;
                end else if (o == 2'b10) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        el = a;
                        eh = '0;
                    end else begin
                        el = 32'(sa / sb);
                        eh = 32'(sa % sb);
                    end
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE (or the done cycle) and check latency, busy and results.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_at, input int stall_len, input bit with_we_lo);
        logic [W-1:0] eh, el, wv;
        logic         ez;
        int           lat, busy_cnt;
        model(o, a, b, eh, el, ez);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        wv    = $urandom;
        if (with_we_lo) begin
            we_lo = 1'b1;
            wdata = wv;
        end
        tick();
        start = 1'b0;
        we_lo = 1'b0;
        if (with_we_lo) check("we_lo_with_start", lo, wv);
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            en = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + stall_len);
            tick();
            lat++;
            if (!done && busy) busy_cnt++;
        end
        en = 1'b1;
        check("latency", lat, W + 2 + stall_len);
        check("busy_cycles", busy_cnt, W + 1 + stall_len);
        check("busy_at_done", busy, 0);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("div_by_zero", div_by_zero, ez);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n_done, n_busy;
        logic [W-1:0] hold_hi, hold_lo;

        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        #4 rst = 1'b1;
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0);

        // back-to-back: each start is asserted in the done cycle of the previous op
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 0, 0);
        run_op(2'b11, 32'd7, 32'd2, -1, 0, 0);
        tick();
        check("done_pulse", done, 0);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0);
        run_op(2'b11, 32'h0000_1234, 32'd0, -1, 0, 0);
        tick();

        // preload LO, start mult, poke start/we_hi while busy, flush in 10th CALC cycle
        we_lo = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        we_lo = 1'b0;
        check("preload_lo", lo, 32'hA5A5_A5A5);
        start = 1'b1; op = 2'b00; srcA = 32'd123; srcB = 32'd456;
        tick();
        we_hi = 1'b1;
        wdata = 32'hDEAD_BEEF;
        repeat (4) tick();
        start = 1'b0;
        we_hi = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            tick();
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("flush_no_done", n_done, 0);
        check("start_not_queued", n_busy, 0);
        check("flush_lo", lo, 32'hA5A5_A5A5);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_dbz", div_by_zero, 1);

        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_beats_start", busy, 0);

        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'h0BAD_F00D;
        tick();
        we_hi = 1'b0;
        we_lo = 1'b0;
        check("both_we_hi", hi, 32'h0BAD_F00D);
        check("both_we_lo", lo, 32'h0BAD_F00D);

        // enable stall mid-CALC, then freeze with done high
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10, 5, 0);
        hold_hi = hi;
        hold_lo = lo;
        en = 1'b0;
        repeat (2) tick();
        check("freeze_done", done, 1);
        check("freeze_hi", hi, hold_hi);
        check("freeze_lo", lo, hold_lo);
        en = 1'b1;
        tick();
        check("unfreeze_done", done, 0);

        // asynchronous reset mid-CALC
        start = 1'b1; op = 2'b11; srcA = 32'hFFFF_0000; srcB = 32'd3;
        tick();
        start = 1'b0;
        repeat (12) tick();
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dbz", div_by_zero, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        repeat (3) tick();
        #2 rst = 1'b1;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done) n_done++;
        end
        check("arst_no_done", n_done, 0);
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, -1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_op(2'($urandom_range(0, 3)), pick(), pick(), -1, 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
